// File: rtl/input_cond_pkg.sv
// Shared types and default parameters for the board input conditioner.
package input_cond_pkg;

    // Command latch state: IDLE waits for a press, HOLD keeps a command until acked.
    typedef enum logic {COND_IDLE, COND_HOLD} cond_state_e;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000;
    localparam int unsigned DEFAULT_SYNC_STAGES     = 2;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: N-flop synchroniser, saturating-free debounce counter and
// stable-level register.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   raw           asynchronous input
//   level         debounced level (registered)
//   accept_c      combinational: level will take the synced value at the next edge
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic accept_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Synchroniser chain, raw enters at bit 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Accept on the DEBOUNCE_CYCLES-th consecutive differing sample; the counter
    // is cleared at that point, so it never exceeds DEBOUNCE_CYCLES-1.
    assign accept_c = (synced != level) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Debounce counter and stable level.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            level <= 1'b0;
        end else if (synced == level) begin
            cnt_q <= '0;
        end else if (accept_c) begin
            cnt_q <= '0;
            level <= synced;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Front end for board buttons and switches: synchronise and debounce every
// input, generate rising-edge pulses for buttons, and latch the first press as
// a command {buttons, switch snapshot} held until acknowledged.
// Optional macro INPUT_COND_FALL_PULSE_EN adds btn_fall (falling-edge pulses).
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   btn_raw       asynchronous button inputs
//   sw_raw        asynchronous switch inputs
//   btn_level     debounced button levels
//   btn_rise      1-cycle pulse per debounced 0->1 button transition
//   btn_fall      (optional) 1-cycle pulse per debounced 1->0 transition
//   sw_level      debounced switch levels
//   cmd_valid     command pending
//   cmd_btn       btn_rise vector captured with the command
//   cmd_sw        sw_level captured with the command
//   cmd_ack       consumer accepts the pending command
//   cmd_drop      sticky: a press arrived while a command was pending
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 3,
    parameter int unsigned NUM_SW          = 2,
    parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_SW-1:0]  sw_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_rise,
`ifdef INPUT_COND_FALL_PULSE_EN
    output logic [NUM_BTN-1:0] btn_fall,
`endif
    output logic [NUM_SW-1:0]  sw_level,
    output logic               cmd_valid,
    output logic [NUM_BTN-1:0] cmd_btn,
    output logic [NUM_SW-1:0]  cmd_sw,
    input  logic               cmd_ack,
    output logic               cmd_drop
);

    logic [NUM_BTN-1:0] btn_accept;
    logic [NUM_SW-1:0]  unused_sw_accept;

    // Debounce channels.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .raw      (btn_raw[i]),
            .level    (btn_level[i]),
            .accept_c (btn_accept[i])
        );
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .raw      (sw_raw[i]),
            .level    (sw_level[i]),
            .accept_c (unused_sw_accept[i])
        );
    end

    // Edge pulses are registered alongside the level update, so they coincide
    // with the first cycle of the new level. An accept always flips the level,
    // so the current level gives the direction.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_rise <= '0;
        end else begin
            btn_rise <= btn_accept & ~btn_level;
        end
    end

`ifdef INPUT_COND_FALL_PULSE_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_fall <= '0;
        end else begin
            btn_fall <= btn_accept & btn_level;
        end
    end
`endif

    cond_state_e        state_q, state_d;
    logic               valid_d;
    logic [NUM_BTN-1:0] btn_d;
    logic [NUM_SW-1:0]  sw_d;
    logic               drop_d;
    logic               any_rise;

    assign any_rise = |btn_rise;

    // Command FSM state and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= COND_IDLE;
            cmd_valid <= 1'b0;
            cmd_btn   <= '0;
            cmd_sw    <= '0;
            cmd_drop  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_valid <= valid_d;
            cmd_btn   <= btn_d;
            cmd_sw    <= sw_d;
            cmd_drop  <= drop_d;
        end
    end

    // Command FSM next-state logic.
    always_comb begin
        state_d = state_q;
        valid_d = cmd_valid;
        btn_d   = cmd_btn;
        sw_d    = cmd_sw;
        drop_d  = cmd_drop;
        case (state_q)
            COND_IDLE: begin
                if (any_rise) begin
                    btn_d   = btn_rise;
                    sw_d    = sw_level;
                    valid_d = 1'b1;
                    state_d = COND_HOLD;
                end
            end
            COND_HOLD: begin
                if (cmd_ack) begin
                    if (any_rise) begin
                        // Back-to-back: replace the acked command in place.
                        btn_d = btn_rise;
                        sw_d  = sw_level;
                    end else begin
                        valid_d = 1'b0;
                        state_d = COND_IDLE;
                    end
                end else if (any_rise) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = COND_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed, table-driven bench for input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_input_conditioner;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] btn_raw;
    logic [1:0] sw_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_rise;
`ifdef INPUT_COND_FALL_PULSE_EN
    logic [2:0] btn_fall;
`endif
    logic [1:0] sw_level;
    logic       cmd_valid;
    logic [2:0] cmd_btn;
    logic [1:0] cmd_sw;
    logic       cmd_ack;
    logic       cmd_drop;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    input_conditioner #(
        .NUM_BTN         (3),
        .NUM_SW          (2),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .sw_raw    (sw_raw),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
`ifdef INPUT_COND_FALL_PULSE_EN
        .btn_fall  (btn_fall),
`endif
        .sw_level  (sw_level),
        .cmd_valid (cmd_valid),
        .cmd_btn   (cmd_btn),
        .cmd_sw    (cmd_sw),
        .cmd_ack   (cmd_ack),
        .cmd_drop  (cmd_drop)
    );

    typedef struct {
        logic [2:0] btn;
        logic [1:0] sw;
        logic       ack;
        logic       rst;
        int         ticks;
        logic [2:0] lvl;
        logic [2:0] rise;
        logic [1:0] swl;
        logic       valid;
        logic [2:0] cbtn;
        logic [1:0] csw;
        logic       drop;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got lvl/rise/swl/valid/cbtn/csw/drop=%b want %b", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %b want %b", name, got, exp);
        end
    endtask

    logic [14:0] got_v;
    logic [14:0] exp_v;

    initial begin
        reset   = 1'b1;
        btn_raw = '0;
        sw_raw  = '0;
        cmd_ack = 1'b0;

        //             btn     sw     ack  rst ticks lvl     rise    swl    vld  cbtn    csw    drop
        vecs.push_back('{3'b000,2'b00,1'b0,1'b1,2, 3'b000,3'b000,2'b00,1'b0,3'b000,2'b00,1'b0,"reset"});
        // 1: single press, exact 6-edge latency
        vecs.push_back('{3'b010,2'b00,1'b0,1'b0,5, 3'b000,3'b000,2'b00,1'b0,3'b000,2'b00,1'b0,"t1_edge5"});
        vecs.push_back('{3'b010,2'b00,1'b0,1'b0,1, 3'b010,3'b010,2'b00,1'b0,3'b000,2'b00,1'b0,"t1_edge6"});
        vecs.push_back('{3'b010,2'b00,1'b0,1'b0,1, 3'b010,3'b000,2'b00,1'b1,3'b010,2'b00,1'b0,"t1_cmd"});
        vecs.push_back('{3'b010,2'b00,1'b1,1'b0,1, 3'b010,3'b000,2'b00,1'b0,3'b010,2'b00,1'b0,"t1_ack"});
        vecs.push_back('{3'b000,2'b00,1'b0,1'b0,6, 3'b000,3'b000,2'b00,1'b0,3'b010,2'b00,1'b0,"t1_release"});
        vecs.push_back('{3'b000,2'b00,1'b1,1'b0,2, 3'b000,3'b000,2'b00,1'b0,3'b010,2'b00,1'b0,"ack_in_idle"});

        for (int i = 0; i < vecs.size(); i++) begin
            btn_raw = vecs[i].btn;
            sw_raw  = vecs[i].sw;
            cmd_ack = vecs[i].ack;
            reset   = vecs[i].rst;
            for (int t = 0; t < vecs[i].ticks; t++) tick();
            got_v = {btn_level, btn_rise, sw_level, cmd_valid, cmd_btn, cmd_sw, cmd_drop};
            exp_v = {vecs[i].lvl, vecs[i].rise, vecs[i].swl, vecs[i].valid,
                     vecs[i].cbtn, vecs[i].csw, vecs[i].drop};
            check(vecs[i].name, got_v, exp_v);
        end

        // 2: 3-cycle glitch on btn[0] must never reach the outputs
        cmd_ack = 1'b0;
        btn_raw = 3'b001;
        for (int t = 0; t < 11; t++) begin
            if (t == 3) btn_raw = 3'b000;
            tick();
            check1("t2_glitch_level", btn_level, 3'b000);
            check1("t2_glitch_rise", btn_rise, 3'b000);
            check1("t2_glitch_valid", {2'b00, cmd_valid}, 3'b000);
        end

        vecs.delete();
        // 3: switch snapshot captured and held
        vecs.push_back('{3'b000,2'b10,1'b0,1'b0,6, 3'b000,3'b000,2'b10,1'b0,3'b010,2'b00,1'b0,"t3_sw_settle"});
        vecs.push_back('{3'b100,2'b10,1'b0,1'b0,6, 3'b100,3'b100,2'b10,1'b0,3'b010,2'b00,1'b0,"t3_press2"});
        vecs.push_back('{3'b100,2'b10,1'b0,1'b0,1, 3'b100,3'b000,2'b10,1'b1,3'b100,2'b10,1'b0,"t3_cmd"});
        vecs.push_back('{3'b100,2'b01,1'b0,1'b0,6, 3'b100,3'b000,2'b01,1'b1,3'b100,2'b10,1'b0,"t3_sw_hold"});
        // 4: drop while pending, then back-to-back capture with ack
        vecs.push_back('{3'b101,2'b01,1'b0,1'b0,6, 3'b101,3'b001,2'b01,1'b1,3'b100,2'b10,1'b0,"t4_rise0"});
        vecs.push_back('{3'b101,2'b01,1'b0,1'b0,1, 3'b101,3'b000,2'b01,1'b1,3'b100,2'b10,1'b1,"t4_drop"});
        vecs.push_back('{3'b111,2'b01,1'b0,1'b0,6, 3'b111,3'b010,2'b01,1'b1,3'b100,2'b10,1'b1,"t4_rise1"});
        vecs.push_back('{3'b111,2'b01,1'b1,1'b0,1, 3'b111,3'b000,2'b01,1'b1,3'b010,2'b01,1'b1,"t4_b2b"});
        // 5: reset with pending command and held inputs
        vecs.push_back('{3'b111,2'b01,1'b0,1'b1,1, 3'b000,3'b000,2'b00,1'b0,3'b000,2'b00,1'b0,"t5_reset"});
        vecs.push_back('{3'b111,2'b01,1'b0,1'b0,5, 3'b000,3'b000,2'b00,1'b0,3'b000,2'b00,1'b0,"t5_edge5"});
        vecs.push_back('{3'b111,2'b01,1'b0,1'b0,1, 3'b111,3'b111,2'b01,1'b0,3'b000,2'b00,1'b0,"t5_edge6"});
        vecs.push_back('{3'b111,2'b01,1'b0,1'b0,1, 3'b111,3'b000,2'b01,1'b1,3'b111,2'b01,1'b0,"t5_cmd"});

        for (int i = 0; i < vecs.size(); i++) begin
            btn_raw = vecs[i].btn;
            sw_raw  = vecs[i].sw;
            cmd_ack = vecs[i].ack;
            reset   = vecs[i].rst;
            for (int t = 0; t < vecs[i].ticks; t++) tick();
            got_v = {btn_level, btn_rise, sw_level, cmd_valid, cmd_btn, cmd_sw, cmd_drop};
            exp_v = {vecs[i].lvl, vecs[i].rise, vecs[i].swl, vecs[i].valid,
                     vecs[i].cbtn, vecs[i].csw, vecs[i].drop};
            check(vecs[i].name, got_v, exp_v);
        end

        // 6: release all buttons with a command pending
        btn_raw = 3'b000;
        for (int t = 1; t <= 7; t++) begin
            tick();
            check1("t6_level", btn_level, (t >= 6) ? 3'b000 : 3'b111);
            check1("t6_rise", btn_rise, 3'b000);
            check1("t6_valid_cbtn", cmd_valid ? cmd_btn : 3'b000, 3'b111);
`ifdef INPUT_COND_FALL_PULSE_EN
            check1("t6_fall", btn_fall, (t == 6) ? 3'b111 : 3'b000);
`endif
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
